// File: rtl/render_pkg.sv
// Shared constants and types for the shape-render chain.
// Coordinate widths, off-screen markers and the raster FSM states.
package render_pkg;

  localparam int X_W     = 11;
  localparam int Y_W     = 12;
  localparam int COLOR_W = 8;

  localparam logic signed [X_W-1:0] OFFSCREEN_X = '1;
  localparam logic signed [Y_W-1:0] OFFSCREEN_Y = '1;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  typedef struct packed {
    logic signed [X_W-1:0] x;
    logic signed [Y_W-1:0] y;
    logic [COLOR_W-1:0]    r;
    logic [COLOR_W-1:0]    g;
    logic [COLOR_W-1:0]    b;
    logic                  valid;
    logic                  sof;
    logic                  eol;
    logic                  eof;
  } pix_t;

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Off-screen coordinates keep every downstream shape test false.
  function automatic pix_t idle_pix(
    logic [COLOR_W-1:0] r,
    logic [COLOR_W-1:0] g,
    logic [COLOR_W-1:0] b
  );
    pix_t p;
    p.x     = OFFSCREEN_X;
    p.y     = OFFSCREEN_Y;
    p.r     = r;
    p.g     = g;
    p.b     = b;
    p.valid = 1'b0;
    p.sof   = 1'b0;
    p.eol   = 1'b0;
    p.eof   = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/pixel_scan_gen_if.sv
// Control and pixel bundle of the raster source.
// master = generator side, slave = consumer/controller side.
interface pixel_scan_gen_if;
  import render_pkg::*;

  logic                  start;
  logic                  continuous;
  logic                  stall;
  logic                  abort;
  logic signed [X_W-1:0] x_out;
  logic signed [Y_W-1:0] y_out;
  logic [COLOR_W-1:0]    r_out;
  logic [COLOR_W-1:0]    g_out;
  logic [COLOR_W-1:0]    b_out;
  logic                  valid;
  logic                  sof;
  logic                  eol;
  logic                  eof;
  logic                  busy;
  logic [15:0]           frame_count;

  modport master (
    input  start,
    input  continuous,
    input  stall,
    input  abort,
    output x_out,
    output y_out,
    output r_out,
    output g_out,
    output b_out,
    output valid,
    output sof,
    output eol,
    output eof,
    output busy,
    output frame_count
  );

  modport slave (
    output start,
    output continuous,
    output stall,
    output abort,
    input  x_out,
    input  y_out,
    input  r_out,
    input  g_out,
    input  b_out,
    input  valid,
    input  sof,
    input  eol,
    input  eof,
    input  busy,
    input  frame_count
  );

endinterface

// File: rtl/pixel_scan_gen_scan_counter.sv
// Modulo-MAX up counter with a same-cycle wrap strobe.
// wrap is high only on the increment that returns count to zero.
module scan_counter #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/pixel_scan_gen.sv
// Row-major raster source feeding the first shape renderer.
// One registered pixel per clock, with off-screen idle output.
module pixel_scan_gen
  import render_pkg::*;
#(
  parameter int                 H_ACTIVE = 640,
  parameter int                 V_ACTIVE = 480,
  parameter logic [COLOR_W-1:0] BG_R     = 8'h00,
  parameter logic [COLOR_W-1:0] BG_G     = 8'h00,
  parameter logic [COLOR_W-1:0] BG_B     = 8'h00
) (
  input logic               clk,
  input logic               rst,
  pixel_scan_gen_if.master  bus
);

  localparam int XCW = cnt_w(H_ACTIVE);
  localparam int YCW = cnt_w(V_ACTIVE);

  localparam logic [XCW-1:0] X_LAST = XCW'(H_ACTIVE - 1);
  localparam logic [YCW-1:0] Y_LAST = YCW'(V_ACTIVE - 1);

  state_t         state;
  state_t         state_nxt;
  logic [XCW-1:0] xc;
  logic [YCW-1:0] yc;
  logic           adv;
  logic           clr;
  logic           x_wrap;
  logic           y_wrap;
  logic           busy_q;
  logic [15:0]    frame_q;
  pix_t           pix_d;
  pix_t           pix_q;

  // Counters sit at zero whenever no frame is running.
  always_comb begin
    adv = (state == SCAN) && !bus.abort && !bus.stall;
    clr = (state == IDLE) || bus.abort;
  end

  scan_counter #(
    .MAX (H_ACTIVE),
    .W   (XCW)
  ) u_xc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (adv),
    .count (xc),
    .wrap  (x_wrap)
  );

  scan_counter #(
    .MAX (V_ACTIVE),
    .W   (YCW)
  ) u_yc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (x_wrap),
    .count (yc),
    .wrap  (y_wrap)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (y_wrap && !bus.continuous) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    pix_d = idle_pix(BG_R, BG_G, BG_B);
    if (adv) begin
      pix_d.valid = 1'b1;
      pix_d.x     = X_W'(xc);
      pix_d.y     = Y_W'(yc);
      pix_d.sof   = (xc == '0) && (yc == '0);
      pix_d.eol   = (xc == X_LAST);
      pix_d.eof   = (xc == X_LAST) && (yc == Y_LAST);
    end
  end

  // busy tracks the output stream, so it rises with (0,0)
  // and falls on the first idle cycle after eof or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pix_q   <= idle_pix(BG_R, BG_G, BG_B);
      busy_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      state  <= state_nxt;
      pix_q  <= pix_d;
      busy_q <= (state == SCAN) && !bus.abort;
      if (y_wrap) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign bus.x_out       = pix_q.x;
  assign bus.y_out       = pix_q.y;
  assign bus.r_out       = pix_q.r;
  assign bus.g_out       = pix_q.g;
  assign bus.b_out       = pix_q.b;
  assign bus.valid       = pix_q.valid;
  assign bus.sof         = pix_q.sof;
  assign bus.eol         = pix_q.eol;
  assign bus.eof         = pix_q.eof;
  assign bus.busy        = busy_q;
  assign bus.frame_count = frame_q;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Scoreboard bench for pixel_scan_gen: 4x3 and 1x1 instances.
// Stimulus queues expected pixels; negedge monitors pop and compare.
module tb_pixel_scan_gen;
  import render_pkg::*;

  localparam int          HA = 4;
  localparam int          VA = 3;
  localparam logic [7:0]  AR = 8'h12;
  localparam logic [7:0]  AG = 8'h34;
  localparam logic [7:0]  AB = 8'h56;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  pixel_scan_gen_if a_if ();
  pixel_scan_gen_if b_if ();

  pixel_scan_gen #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .BG_R     (AR),
    .BG_G     (AG),
    .BG_B     (AB)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  pixel_scan_gen #(
    .H_ACTIVE (1),
    .V_ACTIVE (1),
    .BG_R     (8'h00),
    .BG_G     (8'h00),
    .BG_B     (8'h00)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int compared = 0;
  int mismatched = 0;
  int va_cnt = 0;
  int vb_cnt = 0;
  logic [25:0] qa[$];
  logic [25:0] qb[$];
  logic [25:0] ea;
  logic [25:0] eb;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue the first n pixels of a HA x VA frame.
  task automatic push_a(int n);
    int k = 0;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        if (k < n) begin
          qa.push_back({11'(x), 12'(y), (x == 0 && y == 0),
                        (x == HA - 1), (x == HA - 1 && y == VA - 1)});
          k++;
        end
      end
    end
  endtask

  task automatic start_a();
    a_if.start = 1'b1;
    cyc();
    a_if.start = 1'b0;
  endtask

  task automatic start_b();
    b_if.start = 1'b1;
    cyc();
    b_if.start = 1'b0;
  endtask

  task automatic wait_idle_a(string name);
    int n = 0;
    while (a_if.busy && n < 60) begin
      cyc();
      n++;
    end
    chk(name, 64'(a_if.busy), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_if.valid) begin
        va_cnt++;
        chk("a_pix_expected", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          chk("a_pix",
              {a_if.x_out, a_if.y_out, a_if.sof, a_if.eol,
               a_if.eof, a_if.r_out, a_if.g_out, a_if.b_out},
              {ea, AR, AG, AB});
        end
      end else begin
        chk("a_idle",
            {a_if.x_out, a_if.y_out, a_if.sof, a_if.eol,
             a_if.eof, a_if.r_out, a_if.g_out, a_if.b_out},
            {11'h7FF, 12'hFFF, 3'b000, AR, AG, AB});
      end
      if (b_if.valid) begin
        vb_cnt++;
        chk("b_pix_expected", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          chk("b_pix",
              {b_if.x_out, b_if.y_out, b_if.sof, b_if.eol,
               b_if.eof, b_if.r_out, b_if.g_out, b_if.b_out},
              {eb, 24'h0});
        end
      end else begin
        chk("b_idle",
            {b_if.x_out, b_if.y_out, b_if.sof, b_if.eol,
             b_if.eof, b_if.r_out, b_if.g_out, b_if.b_out},
            {11'h7FF, 12'hFFF, 3'b000, 24'h0});
      end
    end
  end

  initial begin
    int fc0;
    int c0;
    a_if.start = 1'b0;
    a_if.continuous = 1'b0;
    a_if.stall = 1'b0;
    a_if.abort = 1'b0;
    b_if.start = 1'b0;
    b_if.continuous = 1'b0;
    b_if.stall = 1'b0;
    b_if.abort = 1'b0;

    cyc();
    mon_en = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // reset then idle
    chk("rst_fc", 64'(a_if.frame_count), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_valid", 64'(a_if.valid), 64'd0);
      chk("idle_busy", 64'(a_if.busy), 64'd0);
    end

    // single frame
    push_a(12);
    start_a();
    chk("sf_busy_lat", 64'(a_if.busy), 64'd0);
    cyc();
    chk("sf_first_busy", 64'(a_if.busy), 64'd1);
    chk("sf_first_sof", 64'(a_if.sof), 64'd1);
    repeat (11) cyc();
    chk("sf_eof", 64'(a_if.eof), 64'd1);
    chk("sf_fc_on_eof", 64'(a_if.frame_count), 64'd1);
    cyc();
    chk("sf_busy_end", 64'(a_if.busy), 64'd0);
    chk("sf_valid_end", 64'(a_if.valid), 64'd0);

    // stall after (1,0)
    fc0 = int'(a_if.frame_count);
    c0 = va_cnt;
    push_a(12);
    start_a();
    cyc();
    cyc();
    a_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_bubble", 64'(a_if.valid), 64'd0);
      chk("stall_busy", 64'(a_if.busy), 64'd1);
    end
    a_if.stall = 1'b0;
    cyc();
    chk("stall_resume", {a_if.valid, a_if.x_out, a_if.y_out},
        {1'b1, 11'd2, 12'd0});
    wait_idle_a("stall_timeout");
    chk("stall_count", 64'(va_cnt - c0), 64'd12);
    chk("stall_fc", 64'(a_if.frame_count), 64'(fc0 + 1));

    // continuous, three frames
    fc0 = int'(a_if.frame_count);
    c0 = va_cnt;
    push_a(12);
    push_a(12);
    push_a(12);
    a_if.continuous = 1'b1;
    start_a();
    for (int i = 0; i < 35; i++) begin
      cyc();
      chk("cont_no_gap", 64'(a_if.valid), 64'd1);
    end
    a_if.continuous = 1'b0;
    cyc();
    chk("cont_last", {a_if.valid, a_if.eof}, 64'd3);
    cyc();
    chk("cont_busy_end", 64'(a_if.busy), 64'd0);
    chk("cont_fc", 64'(a_if.frame_count), 64'(fc0 + 3));
    chk("cont_count", 64'(va_cnt - c0), 64'd36);

    // abort at (2,1)
    fc0 = int'(a_if.frame_count);
    push_a(7);
    start_a();
    repeat (7) cyc();
    chk("abort_pre", {a_if.x_out, a_if.y_out}, {11'd2, 12'd1});
    a_if.abort = 1'b1;
    cyc();
    a_if.abort = 1'b0;
    chk("abort_valid", 64'(a_if.valid), 64'd0);
    chk("abort_busy", 64'(a_if.busy), 64'd0);
    chk("abort_fc", 64'(a_if.frame_count), 64'(fc0));
    chk("abort_drain", 64'(qa.size()), 64'd0);
    cyc();
    chk("abort_idle_busy", 64'(a_if.busy), 64'd0);
    push_a(12);
    start_a();
    cyc();
    chk("abort_restart_sof", 64'(a_if.sof), 64'd1);
    wait_idle_a("abort_restart_timeout");
    chk("abort_restart_fc", 64'(a_if.frame_count), 64'(fc0 + 1));

    // start with abort
    a_if.start = 1'b1;
    a_if.abort = 1'b1;
    cyc();
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    cyc();
    chk("sa_busy", 64'(a_if.busy), 64'd0);
    chk("sa_valid", 64'(a_if.valid), 64'd0);
    cyc();
    chk("sa_busy2", 64'(a_if.busy), 64'd0);

    // reset during scan
    push_a(3);
    start_a();
    repeat (3) cyc();
    chk("rs_pre_busy", 64'(a_if.busy), 64'd1);
    rst = 1'b1;
    cyc();
    chk("rs_valid", 64'(a_if.valid), 64'd0);
    chk("rs_busy", 64'(a_if.busy), 64'd0);
    chk("rs_fc", 64'(a_if.frame_count), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rs_busy2", 64'(a_if.busy), 64'd0);

    // 1x1 single frame
    qb.push_back({11'd0, 12'd0, 3'b111});
    start_b();
    cyc();
    chk("b_one_valid", 64'(b_if.valid), 64'd1);
    chk("b_one_fc", 64'(b_if.frame_count), 64'd1);
    cyc();
    chk("b_one_busy_end", 64'(b_if.busy), 64'd0);
    chk("b_one_valid_end", 64'(b_if.valid), 64'd0);

    // 1x1 continuous
    fc0 = int'(b_if.frame_count);
    repeat (5) qb.push_back({11'd0, 12'd0, 3'b111});
    b_if.continuous = 1'b1;
    start_b();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("b_cont_valid", 64'(b_if.valid), 64'd1);
      chk("b_cont_fc", 64'(b_if.frame_count), 64'(fc0 + i + 1));
    end
    b_if.continuous = 1'b0;
    cyc();
    chk("b_cont_last", 64'(b_if.valid), 64'd1);
    chk("b_cont_fc_end", 64'(b_if.frame_count), 64'(fc0 + 5));
    cyc();
    chk("b_cont_busy_end", 64'(b_if.busy), 64'd0);
    chk("b_cont_valid_end", 64'(b_if.valid), 64'd0);

    cyc();
    cyc();
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
